// File: rtl/usb_rx_bit_recovery_if.sv
// Signal bundle between the synchronized USB line and the receive deserializer.
// The master drives the line; the slave (bit recovery) produces the recovered stream.
interface usb_rx_bit_recovery_if;
  logic DP;
  logic DM;
  logic NRZI_O;
  logic sample;
  logic stuffed;
  logic SE0;
  logic shift_en;
  logic RX_active;
  logic stuff_err;

  modport master (
    output DP, DM,
    input  NRZI_O, sample, stuffed, SE0, shift_en, RX_active, stuff_err
  );

  modport slave (
    input  DP, DM,
    output NRZI_O, sample, stuffed, SE0, shift_en, RX_active, stuff_err
  );
endinterface

// File: rtl/usb_rx_bit_recovery.sv
// USB receive front end: edge-locked mid-bit strobe recovery, NRZI decode, bit-stuff
// tracking and SYNC/EOP framing ahead of the deserializer.
module usb_rx_bit_recovery #(
  parameter int OVERSAMPLE = 4,
  parameter int SYNC_MIN   = 5,
  parameter int EOP_BITS   = 2
) (
  input logic                  CLK,
  input logic                  RST,
  usb_rx_bit_recovery_if.slave bus
);

  localparam int              PW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PW-1:0]   STROBE_PH = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0]   LAST_PH   = PW'(OVERSAMPLE - 1);
  localparam logic [3:0]      SYNC_MIN_C = 4'(SYNC_MIN);
  localparam logic [3:0]      EOP_BITS_C = 4'(EOP_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_EOP    = 3'd3,
    ST_ABORT  = 3'd4
  } state_t;

  state_t         r_state;
  logic [1:0]     r_line_d;
  logic [PW-1:0]  r_phase;
  logic           r_prev_k;
  logic [2:0]     r_ones;
  logic [3:0]     r_zero_cnt;
  logic [3:0]     r_eop_cnt;
  logic [2:0]     r_abort_j;
  logic           r_abort_se0;
  logic           r_sample;
  logic           r_nrzi;
  logic           r_stuffed;
  logic           r_se0;
  logic           r_shift_en;
  logic           r_rx_active;
  logic           r_stuff_err;

  logic [1:0]     w_line;
  logic           w_edge;
  logic           w_strobe;
  logic           w_is_se0;
  logic           w_is_k;
  logic           w_is_j;
  logic           w_bit;

  // SE1 (11) is folded into J; only 01 is K and 00 is SE0.
  assign w_line   = {bus.DP, bus.DM};
  assign w_edge   = (w_line != r_line_d);
  assign w_strobe = (r_phase == STROBE_PH);
  assign w_is_se0 = (w_line == 2'b00);
  assign w_is_k   = (w_line == 2'b01);
  assign w_is_j   = !w_is_se0 && !w_is_k;
  assign w_bit    = !w_is_se0 && (w_is_k == r_prev_k);

  // Phase tracking, NRZI decode, stuffing and framing FSM, all with registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_line_d    <= 2'b10;
      r_phase     <= '0;
      r_prev_k    <= 1'b0;
      r_ones      <= 3'd0;
      r_zero_cnt  <= 4'd0;
      r_eop_cnt   <= 4'd0;
      r_abort_j   <= 3'd0;
      r_abort_se0 <= 1'b0;
      r_sample    <= 1'b0;
      r_nrzi      <= 1'b0;
      r_stuffed   <= 1'b0;
      r_se0       <= 1'b0;
      r_shift_en  <= 1'b0;
      r_rx_active <= 1'b0;
      r_stuff_err <= 1'b0;
    end else begin
      r_line_d <= w_line;
      if (w_edge || (r_phase == LAST_PH)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end

      r_sample    <= w_strobe;
      r_nrzi      <= 1'b0;
      r_stuffed   <= 1'b0;
      r_stuff_err <= 1'b0;
      // Entering ACTIVE delays shift_en by a cycle so the closing SYNC bit is never shifted.
      r_shift_en  <= (r_state == ST_ACTIVE);

      if (w_strobe) begin
        r_nrzi <= w_bit;
        if (!w_is_se0) begin
          r_prev_k <= w_is_k;
        end

        case (r_state)
          ST_IDLE: begin
            r_ones <= 3'd0;
            if (w_is_k) begin
              r_state    <= ST_SYNC;
              r_zero_cnt <= 4'd1;
            end
          end

          ST_SYNC: begin
            if (w_is_se0) begin
              r_state <= ST_IDLE;
            end else if (!w_bit) begin
              if (r_zero_cnt != 4'd15) begin
                r_zero_cnt <= r_zero_cnt + 4'd1;
              end
            end else if (r_zero_cnt >= SYNC_MIN_C) begin
              r_state     <= ST_ACTIVE;
              r_rx_active <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end

          ST_ACTIVE: begin
            if (w_is_se0) begin
              r_state    <= ST_EOP;
              r_se0      <= 1'b1;
              r_shift_en <= 1'b0;
              r_eop_cnt  <= 4'd1;
              r_ones     <= 3'd0;
            end else if (w_bit) begin
              if (r_ones == 3'd6) begin
                r_stuff_err <= 1'b1;
                r_state     <= ST_ABORT;
                r_shift_en  <= 1'b0;
                r_ones      <= 3'd0;
                r_abort_j   <= 3'd0;
                r_abort_se0 <= 1'b0;
              end else begin
                r_ones <= r_ones + 3'd1;
              end
            end else begin
              r_stuffed <= (r_ones == 3'd6);
              r_ones    <= 3'd0;
            end
          end

          ST_EOP: begin
            if (w_is_se0) begin
              if (r_eop_cnt != 4'd15) begin
                r_eop_cnt <= r_eop_cnt + 4'd1;
              end
            end else begin
              r_state     <= ST_IDLE;
              r_rx_active <= 1'b0;
              r_se0       <= 1'b0;
              if (!(w_is_j && (r_eop_cnt >= EOP_BITS_C))) begin
                r_stuff_err <= 1'b1;
              end
            end
          end

          ST_ABORT: begin
            if (w_is_se0) begin
              r_abort_se0 <= 1'b1;
              r_se0       <= 1'b1;
              r_abort_j   <= 3'd0;
            end else if (w_is_j) begin
              if (r_abort_se0 || (r_abort_j == 3'd7)) begin
                r_state     <= ST_IDLE;
                r_rx_active <= 1'b0;
                r_se0       <= 1'b0;
                r_abort_se0 <= 1'b0;
                r_abort_j   <= 3'd0;
              end else begin
                r_abort_j <= r_abort_j + 3'd1;
              end
            end else begin
              r_abort_j <= 3'd0;
            end
          end

          default: begin
            r_state     <= ST_IDLE;
            r_rx_active <= 1'b0;
            r_se0       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sample    = r_sample;
  assign bus.NRZI_O    = r_nrzi;
  assign bus.stuffed   = r_stuffed;
  assign bus.SE0       = r_se0;
  assign bus.shift_en  = r_shift_en;
  assign bus.RX_active = r_rx_active;
  assign bus.stuff_err = r_stuff_err;

endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Scoreboard bench for usb_rx_bit_recovery: each driven bit queues its expected strobe
// outputs, and every observed strobe pops and compares one entry.
module tb_usb_rx_bit_recovery;

  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] L_K   = 2'b01;
  localparam logic [1:0] L_SE0 = 2'b00;

  typedef struct packed {
    logic nrzi;
    logic stuffed;
    logic shen;
    logic rxa;
    logic se0;
    logic serr;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  usb_rx_bit_recovery_if bus ();

  usb_rx_bit_recovery #(
    .OVERSAMPLE(4),
    .SYNC_MIN  (5),
    .EOP_BITS  (2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  exp_t  sb_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    strobes  = 0;
  bit    tb_prev_k;
  string cur_test;

  task automatic drive_bit(input logic [1:0] ln, input int ncyc, input logic shen,
                           input logic rxa, input logic se0, input logic stuffed,
                           input logic serr);
    exp_t e;
    exp_t x;
    exp_t obs;
    e.nrzi    = (ln != L_SE0) && ((ln == L_K) == tb_prev_k);
    e.stuffed = stuffed;
    e.shen    = shen;
    e.rxa     = rxa;
    e.se0     = se0;
    e.serr    = serr;
    if (ln != L_SE0) tb_prev_k = (ln == L_K);
    sb_q.push_back(e);
    bus.DP = ln[1];
    bus.DM = ln[0];
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      obs = {bus.NRZI_O, bus.stuffed, bus.shift_en, bus.RX_active, bus.SE0, bus.stuff_err};
      if (bus.sample === 1'b1) begin
        strobes++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_strobe: got a strobe, required none (outputs %b)", cur_test, obs);
        end else begin
          x = sb_q.pop_front();
          if (obs !== x) begin
            failures++;
            $display("FAIL %s strobe_outputs: got %b required %b (nrzi,stuffed,shift_en,rx_active,se0,stuff_err)",
                     cur_test, obs, x);
          end
        end
      end else begin
        checks++;
        if ({bus.NRZI_O, bus.stuffed, bus.stuff_err} !== 3'b000) begin
          failures++;
          $display("FAIL %s unqualified_out: got nrzi/stuffed/stuff_err=%b required 000 with sample=%b",
                   cur_test, {bus.NRZI_O, bus.stuffed, bus.stuff_err}, bus.sample);
        end
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_dec(input logic d, input int ncyc, input logic shen, input logic rxa,
                          input logic stuffed, input logic serr);
    logic nk;
    nk = d ? tb_prev_k : !tb_prev_k;
    drive_bit(nk ? L_K : L_J, ncyc, shen, rxa, 1'b0, stuffed, serr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(L_J, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_sync();
    logic [1:0] pat [8];
    pat = '{L_K, L_J, L_K, L_J, L_K, L_J, L_K, L_K};
    for (int i = 0; i < 8; i++) drive_bit(pat[i], 4, 1'b0, (i == 7), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jitter);
    for (int i = 0; i < 8; i++)
      send_dec(b[i], jitter ? ((i % 2 == 0) ? 3 : 5) : 4, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_eop(input bit good);
    drive_bit(L_SE0, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    if (good) drive_bit(L_SE0, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(L_J, 4, 1'b0, 1'b0, 1'b0, 1'b0, !good);
  endtask

  task automatic apply_reset();
    RST    = 1'b0;
    bus.DP = 1'b1;
    bus.DM = 1'b0;
    sb_q.delete();
    tb_prev_k = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic check_drained();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_strobes: got %0d unconsumed bits, required 0", cur_test, sb_q.size());
    end
  endtask

  task automatic test_reset();
    logic [6:0] o;
    cur_test = "reset";
    RST = 1'b0;
    bus.DP = 1'b1;
    bus.DM = 1'b0;
    @(posedge CLK);
    #1;
    o = {bus.sample, bus.NRZI_O, bus.stuffed, bus.SE0, bus.shift_en, bus.RX_active, bus.stuff_err};
    checks++;
    if (o !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000000", o);
    end
  endtask

  task automatic test_idle();
    cur_test = "idle";
    apply_reset();
    strobes = 0;
    idle(10);
    checks++;
    if (strobes != 10) begin
      failures++;
      $display("FAIL idle_strobe_count: got %0d strobes in 40 cycles, required 10", strobes);
    end
    check_drained();
  endtask

  task automatic test_packet();
    cur_test = "packet_a5";
    apply_reset();
    idle(2);
    send_sync();
    send_byte(8'hA5, 1'b0);
    send_eop(1'b1);
    idle(2);
    check_drained();
  endtask

  task automatic test_stuffing();
    cur_test = "stuffing";
    apply_reset();
    idle(2);
    send_sync();
    for (int i = 0; i < 6; i++) send_dec(1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    send_dec(1'b0, 4, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) send_dec(1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    send_eop(1'b1);
    idle(2);
    check_drained();
  endtask

  task automatic test_stuff_err();
    cur_test = "stuff_err";
    apply_reset();
    idle(2);
    send_sync();
    for (int i = 0; i < 6; i++) send_dec(1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    send_dec(1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    drive_bit(L_SE0, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(L_J, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_drained();
  endtask

  task automatic test_short_sync();
    cur_test = "short_sync";
    apply_reset();
    idle(2);
    drive_bit(L_K, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(L_J, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(L_K, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(L_K, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(L_J, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_sync();
    send_byte(8'h3C, 1'b0);
    send_eop(1'b1);
    idle(2);
    check_drained();
  endtask

  task automatic test_jitter();
    cur_test = "jitter";
    apply_reset();
    idle(2);
    send_sync();
    send_byte(8'hA5, 1'b1);
    send_eop(1'b1);
    idle(2);
    check_drained();
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    apply_reset();
    idle(2);
    send_sync();
    send_byte(8'h81, 1'b0);
    send_eop(1'b0);
    send_sync();
    send_byte(8'h5A, 1'b0);
    send_eop(1'b1);
    idle(2);
    check_drained();
  endtask

  task automatic test_reset_mid();
    logic [6:0] o;
    cur_test = "reset_mid";
    apply_reset();
    idle(1);
    send_sync();
    send_dec(1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    send_dec(1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    send_dec(1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    o = {bus.sample, bus.NRZI_O, bus.stuffed, bus.SE0, bus.shift_en, bus.RX_active, bus.stuff_err};
    checks++;
    if (o !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %b required 0000000", o);
    end
    apply_reset();
    idle(2);
    send_sync();
    send_byte(8'h0F, 1'b0);
    send_eop(1'b1);
    idle(2);
    check_drained();
  endtask

  initial begin
    bus.DP = 1'b1;
    bus.DM = 1'b0;
    tb_prev_k = 1'b0;
    test_reset();
    test_idle();
    test_packet();
    test_stuffing();
    test_stuff_err();
    test_short_sync();
    test_jitter();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
